// File: rtl/vxe_vpu_thread_rf_wr.sv
// vxe_vpu_thread_rf_wr
// Accepts register-write commands and drives the thread register file write
// port. It masks data to the target register width and expands CLEAR_ALL into
// six zero writes (ACC, VL, EN, RS, RT, RD) on consecutive cycles.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready is registered)
//   cmd_op[2:0]          target register index, 3'b111 = CLEAR_ALL
//   cmd_data[37:0]       write value (ignored for CLEAR_ALL)
//   ridx[2:0], wr_en,    registered write port to the thread RF
//   data[37:0]
//   busy                 high while CLEAR_ALL writes are presented
//   err                  one-cycle pulse for a rejected command
//
// Optional feature: define VXE_VPU_RFWR_VL_CHECK_EN to reject VL writes whose
// masked value is zero.
module vxe_vpu_thread_rf_wr (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [37:0] cmd_data,
  output logic [2:0]  ridx,
  output logic        wr_en,
  output logic [37:0] data,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DATA_W = 38;
  localparam int unsigned IDX_W  = 3;

  // Register indices, matching the VPU_REG_IDX_* assignments
  localparam logic [IDX_W-1:0] REG_ACC   = 3'd0;
  localparam logic [IDX_W-1:0] REG_VL    = 3'd1;
  localparam logic [IDX_W-1:0] REG_EN    = 3'd2;
  localparam logic [IDX_W-1:0] REG_RD    = 3'd5;
  localparam logic [IDX_W-1:0] CLEAR_ALL = 3'd7;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  logic [IDX_W-1:0]  seq_cnt;

  // Keep only the bits the target register implements
  function automatic logic [DATA_W-1:0] mask_data(input logic [IDX_W-1:0] op,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    m = d;
    case (op)
      REG_ACC: m = {6'd0, d[31:0]};
      REG_VL:  m = {18'd0, d[19:0]};
      REG_EN:  m = {37'd0, d[0]};
      default: m = d;
    endcase
    return m;
  endfunction

  logic              accept;
  logic              op_defined;
  logic              reject;
  logic [DATA_W-1:0] masked;

  // Command classification for the current handshake
  always_comb begin
    accept     = cmd_valid && cmd_ready && (state == IDLE);
    op_defined = (cmd_op <= REG_RD);
    masked     = mask_data(cmd_op, cmd_data);
    reject     = !op_defined && (cmd_op != CLEAR_ALL);
`ifdef VXE_VPU_RFWR_VL_CHECK_EN
    if ((cmd_op == REG_VL) && (masked == '0)) begin
      reject = 1'b1;
    end
`endif
  end

  // Sequencer with registered write-port and status outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      seq_cnt   <= '0;
      cmd_ready <= 1'b0;
      ridx      <= '0;
      wr_en     <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept) begin
            if (cmd_op == CLEAR_ALL) begin
              // First clear write (ACC) goes out with the accepting edge
              state     <= CLEAR;
              seq_cnt   <= 3'd1;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              wr_en     <= 1'b1;
              ridx      <= REG_ACC;
              data      <= '0;
            end else if (reject) begin
              err <= 1'b1;
            end else begin
              wr_en <= 1'b1;
              ridx  <= cmd_op;
              data  <= masked;
            end
          end
        end
        CLEAR: begin
          cmd_ready <= 1'b0;
          // Counter value equals the register index written this step;
          // one step past RD closes the sequence
          if (seq_cnt <= REG_RD) begin
            wr_en   <= 1'b1;
            busy    <= 1'b1;
            ridx    <= seq_cnt;
            data    <= '0;
            seq_cnt <= seq_cnt + 3'd1;
          end else begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            seq_cnt   <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          seq_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vxe_vpu_thread_rf_wr.sv
// Testbench for vxe_vpu_thread_rf_wr: directed scenarios plus random command
// traffic compared every cycle against a behavioural model of the write port.
module tb_vxe_vpu_thread_rf_wr;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [37:0] cmd_data = 38'd0;
  logic        cmd_ready;
  logic [2:0]  ridx;
  logic        wr_en;
  logic [37:0] data;
  logic        busy;
  logic        err;

`ifdef VXE_VPU_RFWR_VL_CHECK_EN
  localparam bit VL_CHECK = 1'b1;
`else
  localparam bit VL_CHECK = 1'b0;
`endif

  vxe_vpu_thread_rf_wr dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .ridx      (ridx),
    .wr_en     (wr_en),
    .data      (data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected outputs after the most recent edge
  bit          m_ready, m_wr, m_busy, m_err, m_in_clear;
  logic [2:0]  m_ridx;
  logic [37:0] m_data;
  int          clr_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [37:0] ref_mask(input logic [2:0] op, input logic [37:0] d);
    int w;
    logic [63:0] m;
    w = (op == 3'd0) ? 32 : (op == 3'd1) ? 20 : (op == 3'd2) ? 1 : 38;
    m = (64'd1 << w) - 64'd1;
    return 38'({26'd0, d} & m);
  endfunction

  task automatic model_reset();
    m_ready = 0; m_wr = 0; m_busy = 0; m_err = 0; m_in_clear = 0;
    m_ridx = 3'd0; m_data = 38'd0;
    clr_q.delete();
  endtask

  // Behaviour at one rising edge, from the inputs held across that edge
  task automatic model_edge();
    logic [37:0] md;
    if (!nrst) begin
      model_reset();
      return;
    end
    m_wr = 0;
    m_err = 0;
    if (m_in_clear) begin
      if (clr_q.size() > 0) begin
        m_wr = 1; m_ridx = 3'(clr_q.pop_front()); m_data = 38'd0;
      end else begin
        m_in_clear = 0; m_busy = 0; m_ready = 1;
      end
      return;
    end
    if (cmd_valid && m_ready) begin
      md = ref_mask(cmd_op, cmd_data);
      if (cmd_op == 3'd7) begin
        m_in_clear = 1; m_busy = 1; m_ready = 0;
        m_wr = 1; m_ridx = 3'd0; m_data = 38'd0;
        for (int k = 1; k <= 5; k++) clr_q.push_back(k);
        return;
      end else if (cmd_op == 3'd6 || (VL_CHECK && cmd_op == 3'd1 && md == 38'd0)) begin
        m_err = 1;
      end else begin
        m_wr = 1; m_ridx = cmd_op; m_data = md;
      end
    end
    m_ready = 1;
    m_busy = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_wr));
    chk({tag, ".ready"}, 64'(cmd_ready), 64'(m_ready));
    chk({tag, ".busy"}, 64'(busy), 64'(m_busy));
    chk({tag, ".err"}, 64'(err), 64'(m_err));
    chk({tag, ".ridx"}, 64'(ridx), 64'(m_ridx));
    chk({tag, ".data"}, 64'(data), 64'(m_data));
  endtask

  task automatic cyc(input string tag, input bit v, input logic [2:0] op, input logic [37:0] d);
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    cyc("reset_hold", 1'b1, 3'd0, 38'd5);
    @(negedge clk);
    nrst = 1'b1;
    cyc("first_edge", 1'b0, 3'd0, 38'd0);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    // ACC write masks to 32 bits
    cyc("acc_mask", 1'b1, 3'd0, 38'h3F_0000_0001);
    chk("acc_data", 64'(data), 64'h1);
    chk("acc_ridx", 64'(ridx), 64'd0);

    // Back-to-back VL, EN, RS
    cyc("b2b_vl", 1'b1, 3'd1, 38'd2);
    cyc("b2b_en", 1'b1, 3'd2, 38'd1);
    chk("b2b_en_data", 64'(data), 64'd1);
    cyc("b2b_rs", 1'b1, 3'd3, 38'd3);
    chk("b2b_rs_data", 64'(data), 64'd3);

    // Wide data on each narrow register
    cyc("vl_mask", 1'b1, 3'd1, 38'h3F_FFFF_FFFF);
    chk("vl_mask_data", 64'(data), 64'hF_FFFF);
    cyc("en_mask", 1'b1, 3'd2, 38'h3F_FFFF_FFFE);
    chk("en_mask_data", 64'(data), 64'h0);
    cyc("rd_full", 1'b1, 3'd5, 38'h3F_FFFF_FFFF);

    // Undefined op: error pulse, write port holds
    cyc("undef", 1'b1, 3'd6, 38'h12345);
    chk("undef_err", 64'(err), 64'd1);
    chk("undef_hold", 64'(data), 64'h3F_FFFF_FFFF);
    cyc("undef_clear", 1'b0, 3'd0, 38'd0);

    // VL = 0 write
    cyc("vl_zero", 1'b1, 3'd1, 38'h10_0000);
    chk("vl_zero_err", 64'(err), 64'(VL_CHECK));
    chk("vl_zero_wr", 64'(wr_en), 64'(!VL_CHECK));

    // CLEAR_ALL with a command held pending throughout
    cyc("clear_acc", 1'b1, 3'd7, 38'd0);
    chk("clear_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 6; i++) cyc("clear_seq", 1'b1, 3'd4, 38'h2A);
    chk("clear_pending_accepted_ridx", 64'(ridx), 64'd5);
    cyc("after_clear", 1'b1, 3'd4, 38'h2A);
    chk("after_clear_data", 64'(data), 64'h2A);

    // Reset during the third clear write
    cyc("clr2_acc", 1'b1, 3'd7, 38'd0);
    cyc("clr2_vl", 1'b0, 3'd0, 38'd0);
    cyc("clr2_en", 1'b0, 3'd0, 38'd0);
    chk("clr2_third_ridx", 64'(ridx), 64'd2);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    cyc("rst_low", 1'b0, 3'd0, 38'd0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) cyc("post_rst", 1'b0, 3'd0, 38'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic [37:0] d;
      op = ($urandom_range(0, 11) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      d  = {6'($urandom), 32'($urandom)};
      if ($urandom_range(0, 5) == 0) d = d & 38'h3F_FFF0_0000;
      cyc("rand", $urandom_range(0, 3) != 0, op, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
